// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU: operation encodings, sequencer
// states and the default datapath width.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [3:0] SEL_ADD_A   = 4'b0000;
    localparam logic [3:0] SEL_ADD_AB  = 4'b0001;
    localparam logic [3:0] SEL_ADD_ANB = 4'b0010;
    localparam logic [3:0] SEL_DEC_A   = 4'b0011;
    localparam logic [3:0] SEL_AND     = 4'b0100;
    localparam logic [3:0] SEL_OR      = 4'b0101;
    localparam logic [3:0] SEL_XOR     = 4'b0110;
    localparam logic [3:0] SEL_NOT     = 4'b0111;
    localparam logic [3:0] SEL_SHR     = 4'b1000;
    localparam logic [3:0] SEL_SHL     = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } seq_state_t;

    function automatic logic is_arith(input logic [3:0] sel);
        return sel[3:2] == 2'b00;
    endfunction

endpackage

// File: rtl/alu_1bit.sv
// One-bit ALU slice: arithmetic with carry, bitwise logic, and a pass-through
// of A for the shift encodings (shifting is done by the sequencer's operand mux).
module alu_1bit
    import alu_pkg::*;
(
    input  logic       a_i,
    input  logic       b_i,
    input  logic       cin_i,
    input  logic [3:0] sel_i,
    output logic       f_o,
    output logic       cout_o
);

    logic y;

    always_comb begin
        y      = 1'b0;
        f_o    = 1'b0;
        cout_o = 1'b0;
        case (sel_i[3:2])
            2'b00: begin
                case (sel_i[1:0])
                    2'b00:   y = 1'b0;
                    2'b01:   y = b_i;
                    2'b10:   y = ~b_i;
                    default: y = 1'b1;
                endcase
                {cout_o, f_o} = {1'b0, a_i} + {1'b0, y} + {1'b0, cin_i};
            end
            2'b01: begin
                case (sel_i)
                    SEL_AND: f_o = a_i & b_i;
                    SEL_OR:  f_o = a_i | b_i;
                    SEL_XOR: f_o = a_i ^ b_i;
                    default: f_o = ~a_i;
                endcase
            end
            default: f_o = a_i;
        endcase
    end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial WIDTH-bit ALU: drives one alu_1bit slice LSB-first, one bit per
// clock, and returns the assembled word over a valid/ready handshake.
//
// state | meaning
// IDLE  | ready for a request; operands captured on valid_i
// RUN   | one bit per cycle through the slice, idx 0..WIDTH-1
// DONE  | result held on f_o/cout_o until ready_i
module alu_serial_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic [3:0]       sel_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] f_o,
    output logic             cout_o
);

    localparam int IW = $clog2(WIDTH);

    seq_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [3:0]       sel_q, sel_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;

    logic [IW-1:0]    idx_p1, idx_m1;
    logic             last;
    logic             sl_a, sl_b, sl_cin, sl_f, sl_cout;
    logic [3:0]       sl_sel;
    logic             final_cout;

    assign idx_p1 = idx_q + IW'(1);
    assign idx_m1 = idx_q - IW'(1);
    assign last   = (idx_q == IW'(WIDTH - 1));

    // Shifts run the slice as a pass-through of the neighbouring A bit.
    always_comb begin
        sl_a   = a_q[idx_q];
        sl_b   = b_q[idx_q];
        sl_cin = carry_q;
        sl_sel = sel_q;
        if (sel_q[3]) begin
            sl_sel = SEL_ADD_A;
            sl_cin = 1'b0;
            sl_b   = 1'b0;
            if (sel_q[2]) begin
                sl_a = (idx_q == '0) ? 1'b0 : a_q[idx_m1];
            end else begin
                sl_a = last ? 1'b0 : a_q[idx_p1];
            end
        end
    end

    alu_1bit u_slice (
        .a_i    (sl_a),
        .b_i    (sl_b),
        .cin_i  (sl_cin),
        .sel_i  (sl_sel),
        .f_o    (sl_f),
        .cout_o (sl_cout)
    );

    always_comb begin
        case (sel_q[3:2])
            2'b00:   final_cout = sl_cout;
            2'b01:   final_cout = 1'b0;
            2'b10:   final_cout = a_q[0];
            default: final_cout = a_q[WIDTH-1];
        endcase
    end

    // The carry register doubles as the cout_o holding register once RUN ends.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sel_d   = sel_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        res_d   = res_q;
        unique case (state_q)
            IDLE: begin
                if (valid_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    sel_d   = sel_i;
                    idx_d   = '0;
                    carry_d = is_arith(sel_i) ? cin_i : 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d   = {sl_f, res_q[WIDTH-1:1]};
                carry_d = last ? final_cout : sl_cout;
                idx_d   = idx_p1;
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            res_q   <= res_d;
        end
    end

    assign ready_o = (state_q == IDLE) && !rst_i;
    assign valid_o = (state_q == DONE);
    assign f_o     = res_q;
    assign cout_o  = carry_q;

endmodule
